seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Time-multiplexed driver for a bank of common-anode seven-segment digits, generalising the single-digit BCD decoder to DIGITS digits with optional hex glyphs, decimal points, leading-zero suppression and global blanking. It sits between the datapath, which presents a packed nibble vector plus a load strobe, and the board pins (shared segment bus plus per-digit anode enables). It double-buffers the displayed value so that updates never tear mid-frame.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8.
- DIV, 50000, clk cycles per digit slot; minimum 2.
- HEX_EN, 1, when 1 nibbles 10..15 render as A b C d E F; when 0 they render as dash.
- LZ_SUPPRESS, 1, when 1 leading zeros are blanked.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- load  in  1  one-cycle strobe; captures value and dp.
- value  in  4*DIGITS  nibble i = digit i; digit 0 is least significant and rightmost.
- dp  in  DIGITS  bit i lights the decimal point of digit i.
- blank  in  1  level; forces all anodes off while high.
- leds  out  [0:6]  segments abcdefg, active-low, shared by all digits.
- dp_n  out  1  decimal-point segment, active-low.
- an  out  DIGITS  anode enables, active-low, one-hot-low while displaying.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Tick counter counts 0..DIV-1. On DIV-1 it returns to 0 and the digit index advances: it increments, and wraps from DIGITS-1 to 0.
- Pending registers (value, dp) load on any cycle with load=1.
- Active registers copy pending when the index wraps to 0. If load coincides with the wrap, the newly presented value/dp goes directly to active.
- Glyphs for the current index use active-low abcdefg encoding:
  - Decimal: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
  - Hex: A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Dash: 1111110.
- Leading-zero suppression: digit i (i>0) gets leds=1111111 when nibble i and every higher nibble are 0. Digit 0 is never suppressed. dp still follows dp[i] on a suppressed digit.
- blank=1: an all ones; leds and dp_n are don't-care but still driven. Scanning and buffering continue unaffected.
- frame_done asserts in the cycle after the index wraps to 0, aligned with the registered outputs.

## Timing
- Reset values: tick=0, index=0, pending=active=0, leds=1111111, dp_n=1, an all ones, frame_done=0.
- Outputs are registered and reflect the index/active state of the previous cycle (1-cycle latency).
- First cycle after reset release: an=...1110 (digit 0 only), leds=0000001 (digit 0 always shown).
- Each digit is shown for exactly DIV cycles; the frame period is DIGITS*DIV cycles.
- Load-to-visible latency is at most DIGITS*DIV+1 cycles, and at least 1 cycle when load lands on the wrap.
- An `an` transition changes exactly one low bit per slot; there are no cycles with two anodes active.
- DIGITS=1: the index stays 0, the wrap happens every DIV cycles, and frame_done pulses every DIV cycles.
- reset mid-frame: all state returns to reset values on the next edge; the pending load is discarded.

## Structure
- Shared package seg_pkg: the 7-bit active-low glyph constants (digits 0..9, A..F, DASH, OFF), and the nibble type.
- Sub-module seg_decode: combinational nibble+HEX_EN -> glyph lookup, which replaces the legacy single-digit decoder. The scanner instantiates it once on the muxed nibble.
- Top module holds the tick counter, index counter, pending/active buffers, suppression logic and output registers.

## Test plan
All scenarios use DIGITS=4 and DIV=4.
- Reset then idle: an cycles 1110,1101,1011,0111 every 4 clocks. With LZ_SUPPRESS=1, leds=0000001 on digit 0 and 1111111 on the others. frame_done pulses every 16 clocks.
- load value=16'h1234, dp=4'b0100 mid-frame: the old value holds until the wrap. Then digit 3 shows 1001111, digit 2 shows 0010010 with dp_n=0, digit 1 shows 0000110, digit 0 shows 1001100.
- load 16'h00AF with HEX_EN=1: digits 3,2 are blank, digit 1=0001000, digit 0=0111000. With HEX_EN=0, digits 1 and 0 each show 1111110.
- load 16'h0000 asserted in the same cycle as the wrap: the active value updates immediately. Only digit 0 lights, showing 0000001.
- Assert blank for 10 cycles: an=1111 throughout. The index keeps advancing, and on release the display resumes on the correct digit with no phase slip.
- Assert reset during digit 2 after loading 16'h5678: the next cycle gives an=1111 and leds=1111111. The following cycle shows digit 0 as 0000001, with pending and active cleared.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph constants and nibble type for the seven-segment display path.
// Glyphs are active-low, ordered abcdefg with segment a in the MSB.
package seg_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] glyph_t;

    localparam glyph_t GLYPH_0    = 7'b0000001;
    localparam glyph_t GLYPH_1    = 7'b1001111;
    localparam glyph_t GLYPH_2    = 7'b0010010;
    localparam glyph_t GLYPH_3    = 7'b0000110;
    localparam glyph_t GLYPH_4    = 7'b1001100;
    localparam glyph_t GLYPH_5    = 7'b0100100;
    localparam glyph_t GLYPH_6    = 7'b0100000;
    localparam glyph_t GLYPH_7    = 7'b0001111;
    localparam glyph_t GLYPH_8    = 7'b0000000;
    localparam glyph_t GLYPH_9    = 7'b0001100;
    localparam glyph_t GLYPH_A    = 7'b0001000;
    localparam glyph_t GLYPH_B    = 7'b1100000;
    localparam glyph_t GLYPH_C    = 7'b0110001;
    localparam glyph_t GLYPH_D    = 7'b1000010;
    localparam glyph_t GLYPH_E    = 7'b0110000;
    localparam glyph_t GLYPH_F    = 7'b0111000;
    localparam glyph_t GLYPH_DASH = 7'b1111110;
    localparam glyph_t GLYPH_OFF  = 7'b1111111;

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-glyph lookup. With HEX_EN=0 the values 10..15
// render as a dash so a non-BCD value is visibly wrong rather than misleading.
module seg_decode
    import seg_pkg::*;
#(
    parameter int HEX_EN = 1
) (
    input  nibble_t nibble,
    output glyph_t  glyph
);

    localparam bit HEX_ON = (HEX_EN != 0);

    always_comb begin
        glyph = GLYPH_DASH;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = HEX_ON ? GLYPH_A : GLYPH_DASH;
            4'hB: glyph = HEX_ON ? GLYPH_B : GLYPH_DASH;
            4'hC: glyph = HEX_ON ? GLYPH_C : GLYPH_DASH;
            4'hD: glyph = HEX_ON ? GLYPH_D : GLYPH_DASH;
            4'hE: glyph = HEX_ON ? GLYPH_E : GLYPH_DASH;
            4'hF: glyph = HEX_ON ? GLYPH_F : GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode display driver with a double-buffered value:
// new values are captured into pending and promoted to active only at frame wrap.
module seven_segment_scanner
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIV         = 50000,
    parameter int HEX_EN      = 1,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank,
    output logic [0:6]            leds,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TICK_W = $clog2(DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [TICK_W-1:0]   tick_reg;
    logic [IDX_W-1:0]    index_reg;
    logic [4*DIGITS-1:0] pend_value_reg;
    logic [DIGITS-1:0]   pend_dp_reg;
    logic [4*DIGITS-1:0] act_value_reg;
    logic [DIGITS-1:0]   act_dp_reg;
    logic                wrapped_reg;
    glyph_t              leds_reg;
    logic                dp_n_reg;
    logic [DIGITS-1:0]   an_reg;
    logic                frame_done_reg;

    logic                tick_last;
    logic                wrap;
    nibble_t             act_nibble [DIGITS];
    logic [DIGITS-1:0]   zero_from;
    logic [DIGITS-1:0]   an_next;
    nibble_t             cur_nibble;
    glyph_t              cur_glyph;
    logic                suppress;

    assign tick_last = (tick_reg == TICK_LAST);
    assign wrap      = tick_last && (index_reg == IDX_LAST);

    // zero_from[i]: nibble i and everything above it are zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign act_nibble[gi] = act_value_reg[4*gi +: 4];
        assign zero_from[gi]  = ~|act_value_reg[4*DIGITS-1:4*gi];
        assign an_next[gi]    = (index_reg != IDX_W'(gi));
    end

    assign cur_nibble = act_nibble[index_reg];
    assign suppress   = (LZ_SUPPRESS != 0) && (index_reg != '0) && zero_from[index_reg];

    seg_decode #(
        .HEX_EN (HEX_EN)
    ) u_decode (
        .nibble (cur_nibble),
        .glyph  (cur_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_reg       <= '0;
            index_reg      <= '0;
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            act_value_reg  <= '0;
            act_dp_reg     <= '0;
            wrapped_reg    <= 1'b0;
            leds_reg       <= GLYPH_OFF;
            dp_n_reg       <= 1'b1;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            tick_reg <= tick_last ? '0 : tick_reg + TICK_W'(1);
            if (tick_last) begin
                index_reg <= (index_reg == IDX_LAST) ? '0 : index_reg + IDX_W'(1);
            end

            if (load) begin
                pend_value_reg <= value;
                pend_dp_reg    <= dp;
            end

            // A load landing on the wrap bypasses pending so it is not lost for a frame.
            if (wrap) begin
                act_value_reg <= load ? value : pend_value_reg;
                act_dp_reg    <= load ? dp    : pend_dp_reg;
            end

            // Delayed twice so the pulse lines up with the first registered digit-0 output.
            wrapped_reg    <= wrap;
            frame_done_reg <= wrapped_reg;

            leds_reg <= suppress ? GLYPH_OFF : cur_glyph;
            dp_n_reg <= ~act_dp_reg[index_reg];
            an_reg   <= blank ? '1 : an_next;
        end
    end

    assign leds       = leds_reg;
    assign dp_n       = dp_n_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: a behavioural model pushes the expected outputs every clock,
// scenario tasks pop and compare at the falling edge and add spot checks on known glyphs.
module tb_seven_segment_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        reset, load, blank;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [0:6]  leds, leds_nh;
    logic        dp_n, dp_n_nh;
    logic [3:0]  an, an_nh;
    logic        frame_done, fd_nh;

    typedef struct packed {
        logic [6:0] leds;
        logic [6:0] leds_nh;
        logic       dp_n;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_tick, m_idx;
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pdp, m_adp;
    logic        m_fd;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .DIGITS(DIGITS), .DIV(DIV), .HEX_EN(1), .LZ_SUPPRESS(1)
    ) u_dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp), .blank(blank),
        .leds(leds), .dp_n(dp_n), .an(an), .frame_done(frame_done)
    );

    seven_segment_scanner #(
        .DIGITS(DIGITS), .DIV(DIV), .HEX_EN(0), .LZ_SUPPRESS(1)
    ) u_dut_nh (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp), .blank(blank),
        .leds(leds_nh), .dp_n(dp_n_nh), .an(an_nh), .frame_done(fd_nh)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] n, input bit hex);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b0000001;  4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;  4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;  4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;  4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;  4'h9: g = 7'b0001100;
            4'hA: g = 7'b0001000;  4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;  4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;  default: g = 7'b0111000;
        endcase
        if (!hex && n > 4'h9) g = 7'b1111110;
        return g;
    endfunction

    function automatic int an_digit(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [25:0] dut_obs();
        return {leds, leds_nh, dp_n, an, frame_done, dp_n_nh, an_nh, fd_nh};
    endfunction

    function automatic logic [25:0] exp_obs(input exp_t e);
        return {e.leds, e.leds_nh, e.dp_n, e.an, e.fd, e.dp_n, e.an, e.fd};
    endfunction

    // Reference model: the expectation for the outputs after this edge comes
    // from the model state before the edge.
    task automatic model_step();
        exp_t       e;
        logic [3:0] nib;
        bit         sup, wrap;
        if (reset) begin
            e = '{leds: 7'h7F, leds_nh: 7'h7F, dp_n: 1'b1, an: 4'hF, fd: 1'b0};
            m_tick = 0; m_idx = 0; m_pv = '0; m_pdp = '0; m_av = '0; m_adp = '0; m_fd = 1'b0;
        end else begin
            nib       = m_av[m_idx*4 +: 4];
            sup       = (m_idx != 0) && ((m_av >> (4*m_idx)) == 16'h0);
            e.leds    = sup ? 7'h7F : ref_glyph(nib, 1'b1);
            e.leds_nh = sup ? 7'h7F : ref_glyph(nib, 1'b0);
            e.dp_n    = ~m_adp[m_idx];
            e.an      = blank ? 4'hF : ~(4'b0001 << m_idx);
            e.fd      = m_fd;
            wrap = (m_tick == DIV-1) && (m_idx == DIGITS-1);
            if (wrap) begin
                m_av  = load ? value : m_pv;
                m_adp = load ? dp : m_pdp;
            end
            if (load) begin
                m_pv  = value;
                m_pdp = dp;
            end
            m_fd = wrap;
            if (m_tick == DIV-1) begin
                m_tick = 0;
                m_idx  = (m_idx == DIGITS-1) ? 0 : m_idx + 1;
            end else begin
                m_tick = m_tick + 1;
            end
        end
        sb_q.push_back(e);
    endtask

    always @(posedge clk) model_step();

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_reset underflow"); end
            else begin
                e = sb_q.pop_front();
                if (dut_obs() !== exp_obs(e)) begin n_fail++; $display("FAIL sb_reset got=%h exp=%h", dut_obs(), exp_obs(e)); end
            end
            if (c == 2) begin
                n_checks++;
                if ({an, leds, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                    n_fail++; $display("FAIL reset_state an=%b leds=%b dp_n=%b fd=%b", an, leds, dp_n, frame_done);
                end
                reset = 1'b0;
            end
            if (c == 3) begin
                n_checks++;
                if ({an, leds} !== {4'b1110, 7'b0000001}) begin
                    n_fail++; $display("FAIL first_after_reset an=%b leds=%b exp an=1110 leds=0000001", an, leds);
                end
            end
        end
    endtask

    task automatic test_idle();
        exp_t e;
        int pulses = 0, last_fd = -1;
        for (int c = 0; c < 2*FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_idle underflow"); end
            else begin
                e = sb_q.pop_front();
                if (dut_obs() !== exp_obs(e)) begin n_fail++; $display("FAIL sb_idle got=%h exp=%h", dut_obs(), exp_obs(e)); end
            end
            n_checks++;
            if ($countones(~an) != 1 || (an == 4'b1110 ? leds !== 7'b0000001 : leds !== 7'b1111111)) begin
                n_fail++; $display("FAIL idle_glyph an=%b leds=%b", an, leds);
            end
            if (frame_done) begin
                pulses++;
                if (last_fd >= 0) begin
                    n_checks++;
                    if (c - last_fd != FRAME) begin n_fail++; $display("FAIL fd_period got=%0d exp=%0d", c - last_fd, FRAME); end
                end
                last_fd = c;
            end
        end
        n_checks++;
        if (pulses != 2) begin n_fail++; $display("FAIL fd_count got=%0d exp=2", pulses); end
    endtask

    task automatic test_load_1234();
        exp_t e;
        logic [6:0] want [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        bit fired = 0, seen_fd = 0;
        int d;
        for (int c = 0; c < 3*FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_load underflow"); end
            else begin
                e = sb_q.pop_front();
                if (dut_obs() !== exp_obs(e)) begin n_fail++; $display("FAIL sb_load got=%h exp=%h", dut_obs(), exp_obs(e)); end
            end
            if (fired && frame_done) seen_fd = 1;
            d = an_digit(an);
            if (fired && !seen_fd && d == 0) begin
                n_checks++;
                if (leds !== 7'b0000001) begin n_fail++; $display("FAIL load_hold leds=%b exp=0000001", leds); end
            end
            if (seen_fd) begin
                n_checks++;
                if (d < 0 || leds !== want[d] || dp_n !== (d != 2)) begin
                    n_fail++; $display("FAIL load_1234 an=%b leds=%b dp_n=%b", an, leds, dp_n);
                end
            end
            load = 1'b0;
            if (!fired && m_idx == 1) begin
                load = 1'b1; value = 16'h1234; dp = 4'b0100; fired = 1;
            end
        end
        n_checks++;
        if (!seen_fd) begin n_fail++; $display("FAIL load_1234_timeout fired=%0d seen_fd=0 exp=1", fired); end
    endtask

    task automatic test_hex();
        exp_t e;
        logic [6:0] want_h  [4] = '{7'b0111000, 7'b0001000, 7'b1111111, 7'b1111111};
        logic [6:0] want_nh [4] = '{7'b1111110, 7'b1111110, 7'b1111111, 7'b1111111};
        bit fired = 0, seen_fd = 0;
        int d;
        for (int c = 0; c < 3*FRAME; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_hex underflow"); end
            else begin
                e = sb_q.pop_front();
                if (dut_obs() !== exp_obs(e)) begin n_fail++; $display("FAIL sb_hex got=%h exp=%h", dut_obs(), exp_obs(e)); end
            end
            if (fired && frame_done) seen_fd = 1;
            d = an_digit(an);
            if (seen_fd) begin
                n_checks++;
                if (d < 0 || leds !== want_h[d] || leds_nh !== want_nh[d]) begin
                    n_fail++; $display("FAIL hex_00af an=%b leds=%b leds_nohex=%b", an, leds, leds_nh);
                end
            end
            load = 1'b0;
            if (!fired && m_idx == 1) begin
                load = 1'b1; value = 16'h00AF; dp = 4'b0000; fired = 1;
            end
        end
        n_checks++;
        if (!seen_fd) begin n_fail++; $display("FAIL hex_timeout fired=%0d seen_fd=0 exp=1", fired); end
    endtask

    task automatic test_load_on_wrap();
        exp_t e;
        int k = -1;
        for (int c = 0; c < 3*FRAME && k < FRAME + 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_wrap underflow"); end
            else begin
                e = sb_q.pop_front();
                if (dut_obs() !== exp_obs(e)) begin n_fail++; $display("FAIL sb_wrap got=%h exp=%h", dut_obs(), exp_obs(e)); end
            end
            if (k >= 0) k++;
            if (k == 2) begin
                n_checks++;
                if ({an, leds, frame_done} !== {4'b1110, 7'b0000001, 1'b1}) begin
                    n_fail++; $display("FAIL wrap_bypass an=%b leds=%b fd=%b exp an=1110 leds=0000001 fd=1", an, leds, frame_done);
                end
            end else if (k > 2 && an != 4'b1110) begin
                n_checks++;
                if (leds !== 7'b1111111) begin n_fail++; $display("FAIL wrap_zero_blank an=%b leds=%b", an, leds); end
            end
            load = 1'b0;
            if (k < 0 && m_tick == DIV-1 && m_idx == DIGITS-1) begin
                load = 1'b1; value = 16'h0000; dp = 4'b0000; k = 0;
            end
        end
        n_checks++;
        if (k < FRAME + 2) begin n_fail++; $display("FAIL wrap_timeout k=%0d exp=%0d", k, FRAME + 2); end
    endtask

    task automatic test_blank();
        exp_t e;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_blank underflow"); end
            else begin
                e = sb_q.pop_front();
                if (dut_obs() !== exp_obs(e)) begin n_fail++; $display("FAIL sb_blank got=%h exp=%h", dut_obs(), exp_obs(e)); end
            end
            if (c >= 1 && c <= 10) begin
                n_checks++;
                if (an !== 4'hF) begin n_fail++; $display("FAIL blank_an got=%b exp=1111", an); end
            end
            blank = (c < 10);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int st = 0, cnt = 0;
        for (int c = 0; c < 6*FRAME && st < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (sb_q.size() == 0) begin n_fail++; $display("FAIL sb_rst underflow"); end
            else begin
                e = sb_q.pop_front();
                if (dut_obs() !== exp_obs(e)) begin n_fail++; $display("FAIL sb_rst got=%h exp=%h", dut_obs(), exp_obs(e)); end
            end
            load = 1'b0;
            case (st)
                0: begin load = 1'b1; value = 16'h5678; dp = 4'b0000; st = 1; end
                1: if (frame_done) begin load = 1'b1; value = 16'h9999; st = 2; end
                2: if (m_idx == 2) begin reset = 1'b1; st = 3; end
                3: begin
                    n_checks++;
                    if ({an, leds, dp_n, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                        n_fail++; $display("FAIL rst_mid_state an=%b leds=%b dp_n=%b fd=%b", an, leds, dp_n, frame_done);
                    end
                    reset = 1'b0; st = 4;
                end
                4: begin
                    n_checks++;
                    if ({an, leds} !== {4'b1110, 7'b0000001}) begin
                        n_fail++; $display("FAIL rst_mid_first an=%b leds=%b exp an=1110 leds=0000001", an, leds);
                    end
                    st = 5;
                end
                default: begin
                    if (an == 4'b1110) begin
                        n_checks++;
                        if (leds !== 7'b0000001) begin n_fail++; $display("FAIL rst_pending_discard leds=%b exp=0000001", leds); end
                    end
                    cnt++;
                    if (cnt == FRAME + 4) st = 6;
                end
            endcase
        end
        n_checks++;
        if (st != 6) begin n_fail++; $display("FAIL rst_mid_timeout state=%0d exp=6", st); end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; blank = 1'b0; value = '0; dp = '0;
        test_reset();
        test_idle();
        test_load_1234();
        test_hex();
        test_load_on_wrap();
        test_blank();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
